// File: rtl/lbm_step_sequencer_pkg.sv
// Shared definitions for the LBM control path: state codes (also the oStatus values)
// and the step counter width.
`timescale 1ns/1ps
package lbm_ctrl_pkg;

    localparam int unsigned STEP_CNT_W = 16;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_WAIT  = 4'd1,
        ST_START = 4'd2,
        ST_RUN   = 4'd3,
        ST_ERR   = 4'd4
    } state_e;

endpackage

// File: rtl/lbm_step_sequencer_if.sv
// Start/done handshake between the step sequencer (master) and the LBM solver (slave).
`timescale 1ns/1ps
interface lbm_step_sequencer_if;

    logic oSolver_Start;
    logic iSolver_Done;

    modport master (output oSolver_Start, input iSolver_Done);
    modport slave  (input oSolver_Start, output iSolver_Done);

endinterface

// File: rtl/lbm_step_sequencer_key_debounce.sv
// Active-low push-button conditioner: 2-flop synchronizer, symmetric debounce,
// and a single-cycle press pulse per debounced press.
`timescale 1ns/1ps
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_n_i,
    output logic press_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] RUN_FULL = CNT_W'(DEBOUNCE_CYCLES);

    logic             key_s1_q, key_s2_q;
    logic             last_q;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] run_q, run_d;

    // run_d is the length of the current constant-level run including this cycle,
    // saturating so a held level keeps matching without wrapping.
    always_comb begin
        run_d   = CNT_W'(1);
        armed_d = armed_q;
        press_o = 1'b0;
        if (key_s2_q == last_q) begin
            run_d = (run_q == RUN_FULL) ? run_q : run_q + 1'b1;
        end
        if (run_d == RUN_FULL) begin
            if (!key_s2_q && armed_q) begin
                press_o = 1'b1;
                armed_d = 1'b0;
            end else if (key_s2_q) begin
                armed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_s1_q <= 1'b1;
            key_s2_q <= 1'b1;
            last_q   <= 1'b1;
            armed_q  <= 1'b1;
            run_q    <= '0;
        end else begin
            key_s1_q <= key_n_i;
            key_s2_q <= key_s1_q;
            last_q   <= key_s2_q;
            armed_q  <= armed_d;
            run_q    <= run_d;
        end
    end

endmodule

// File: rtl/lbm_step_sequencer.sv
// Decides when the LBM solver advances one lattice step: free-run on VGA frame ends or
// single-step on a debounced key press, with start/done handshake, overrun and timeout flags.
`timescale 1ns/1ps
module lbm_step_sequencer
    import lbm_ctrl_pkg::*;
#(
    parameter int unsigned FRAME_END_X     = 638,
    parameter int unsigned FRAME_END_Y     = 479,
    parameter int unsigned FRAMES_PER_STEP = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned TIMEOUT_CYCLES  = 2**20
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic                  iSingle_Mode,
    input  logic                  iStep_Key_N,
    input  logic [9:0]            iCoord_X,
    input  logic [9:0]            iCoord_Y,
    lbm_step_sequencer_if.master  solver,
    output logic [STEP_CNT_W-1:0] oStep_Count,
    output logic                  oOverrun,
    output logic                  oError,
    output logic [3:0]            oStatus
);

    localparam int unsigned FC_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [FC_W-1:0]  FC_TERM  = FC_W'(FRAMES_PER_STEP - 1);
    localparam logic [TMO_W-1:0] TMO_TERM = TMO_W'(TIMEOUT_CYCLES - 1);

    logic                  mode_s1_q, mode_s2_q, mode_d1_q;
    logic                  match_q, fe_q;
    logic [FC_W-1:0]       frame_cnt_q, frame_cnt_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic                  overrun_q, overrun_d;
    logic                  error_q, error_d;
    state_e                state_q, state_d;

    logic match, press, free_trig, step_trig, start;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clk_i  (iCLK),
        .rst_ni (iRST_N),
        .key_n_i(iStep_Key_N),
        .press_o(press)
    );

    assign match = (iCoord_X == 10'(FRAME_END_X)) && (iCoord_Y == 10'(FRAME_END_Y));

    always_comb begin
        free_trig   = fe_q && !mode_s2_q && (frame_cnt_q == FC_TERM);
        step_trig   = press && mode_s2_q;
        frame_cnt_d = frame_cnt_q;
        state_d     = state_q;
        tmo_d       = tmo_q;
        step_cnt_d  = step_cnt_q;
        overrun_d   = overrun_q;
        error_d     = error_q;
        start       = 1'b0;

        if (mode_s2_q != mode_d1_q) begin
            frame_cnt_d = '0;
        end else if (fe_q && !mode_s2_q) begin
            frame_cnt_d = (frame_cnt_q == FC_TERM) ? '0 : frame_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (free_trig || step_trig) state_d = ST_START;
            end
            ST_START: begin
                start     = 1'b1;
                tmo_d     = '0;
                state_d   = ST_RUN;
                overrun_d = overrun_q || free_trig;
            end
            ST_RUN: begin
                overrun_d = overrun_q || free_trig;
                // Done has priority over a timeout landing in the same cycle.
                if (solver.iSolver_Done) begin
                    state_d    = ST_WAIT;
                    step_cnt_d = step_cnt_q + 1'b1;
                end else if (tmo_q == TMO_TERM) begin
                    state_d = ST_ERR;
                    error_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            mode_s1_q   <= 1'b0;
            mode_s2_q   <= 1'b0;
            mode_d1_q   <= 1'b0;
            match_q     <= 1'b0;
            fe_q        <= 1'b0;
            frame_cnt_q <= '0;
            tmo_q       <= '0;
            step_cnt_q  <= '0;
            overrun_q   <= 1'b0;
            error_q     <= 1'b0;
            state_q     <= ST_IDLE;
        end else begin
            mode_s1_q   <= iSingle_Mode;
            mode_s2_q   <= mode_s1_q;
            mode_d1_q   <= mode_s2_q;
            match_q     <= match;
            fe_q        <= match && !match_q;
            frame_cnt_q <= frame_cnt_d;
            tmo_q       <= tmo_d;
            step_cnt_q  <= step_cnt_d;
            overrun_q   <= overrun_d;
            error_q     <= error_d;
            state_q     <= state_d;
        end
    end

    assign solver.oSolver_Start = start;
    assign oStep_Count          = step_cnt_q;
    assign oOverrun             = overrun_q;
    assign oError               = error_q;
    assign oStatus              = state_q;

endmodule
